mem_refill_responder: RTL and testbench

- Memory-side responder for the cache controller's refill interface (req_cc2mem/adr_cc2mem in, ack_mem2cc/dat_mem2cc/word_mem2mshr out).
- Accepts one line-refill request at a time, waits a programmable latency, then returns one cache line as a contiguous burst of WORDS_PER_LINE word beats.
- Data comes from an internal word RAM, preloadable through a side port.
- Used as the memory model in cache-controller benches and as the FPGA-prototype backing store.

---
 rtl/mem_resp_pkg.sv | 21 ++
 rtl/mem_resp_ram.sv | 39 +++
 rtl/mem_refill_responder.sv | 147 ++++++++++++++
 tb/tb_mem_refill_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the refill responder: FSM states, line geometry
// helpers and the latency counter width.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned LAT_CNT_W = 8;

    function automatic int unsigned words_per_line(input int unsigned word_offset);
        return 32'd1 << word_offset;
    endfunction

    localparam int unsigned WORD_OFFSET_DEFAULT = 2;
    localparam int unsigned WORDS_PER_LINE      = words_per_line(WORD_OFFSET_DEFAULT);

endpackage

// File: rtl/mem_resp_ram.sv
// Word RAM behind the responder: registered read port plus an independent
// write port. A read and write to the same word on one edge returns the
// old contents. Only the read register is reset; contents survive reset.
module mem_resp_ram #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_adr,
    output logic [DATA_WIDTH-1:0] o_rd_dat,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_adr,
    input  logic [DATA_WIDTH-1:0] i_wr_dat
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**DEPTH_LOG2)-1];
    logic [DATA_WIDTH-1:0] r_rd_dat;

    // Preload write port, active in every state.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_adr] <= i_wr_dat;
        end
    end

    // Read register; holds its value whenever no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_adr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/mem_refill_responder.sv
// Memory-side refill responder: accepts one line request, waits LATENCY
// cycles, then returns the line as a gap-free burst of word beats.
// Build option: define MEM_RESP_CWF_EN for critical-word-first ordering;
// otherwise beats always run from offset 0 upwards.
module mem_refill_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WORD_OFFSET    = WORD_OFFSET_DEFAULT,
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY        = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_cc2mem,
    input  logic [ADR_WIDTH-1:0]      adr_cc2mem,
    output logic                      ack_mem2cc,
    output logic [DATA_WIDTH-1:0]     dat_mem2cc,
    output logic [WORD_OFFSET-1:0]    word_mem2mshr,
    input  logic                      ld_en,
    input  logic [MEM_DEPTH_LOG2-1:0] ld_adr,
    input  logic [DATA_WIDTH-1:0]     ld_dat,
    output logic                      busy
);

    localparam int unsigned    WPL      = words_per_line(WORD_OFFSET);
    localparam int unsigned    LINE_W   = MEM_DEPTH_LOG2 - WORD_OFFSET;
    localparam logic [WORD_OFFSET:0] BEATS    = (WORD_OFFSET+1)'(WPL);
    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LATENCY - 1);

    state_t                  r_state, w_state_nxt;
    logic [LAT_CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [WORD_OFFSET:0]    r_beat, w_beat_nxt;
    logic [LINE_W-1:0]       r_line, w_line_nxt;
    logic [WORD_OFFSET-1:0]  r_start, w_start_nxt;
    logic                    r_ack;
    logic [WORD_OFFSET-1:0]  r_word;
    logic                    r_busy;
    logic                    w_issue;
    logic [WORD_OFFSET-1:0]  w_off;
    logic [MEM_DEPTH_LOG2-1:0] w_rd_adr;
    logic                    w_unused;

`ifdef MEM_RESP_CWF_EN
    assign w_off    = r_start + r_beat[WORD_OFFSET-1:0];
    assign w_unused = ^{adr_cc2mem[ADR_WIDTH-1:MEM_DEPTH_LOG2+2], adr_cc2mem[1:0]};
`else
    assign w_off    = r_beat[WORD_OFFSET-1:0];
    assign w_unused = ^{adr_cc2mem[ADR_WIDTH-1:MEM_DEPTH_LOG2+2], adr_cc2mem[1:0], r_start};
`endif

    assign w_rd_adr = {r_line, w_off};

    // Next-state and read-issue logic; a read issued this cycle becomes the
    // beat presented after the next edge, so ack/data line up with the RAM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        w_line_nxt  = r_line;
        w_start_nxt = r_start;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_cc2mem) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = LAT_INIT;
                    w_beat_nxt  = '0;
                    w_line_nxt  = adr_cc2mem[MEM_DEPTH_LOG2+1:WORD_OFFSET+2];
                    w_start_nxt = adr_cc2mem[WORD_OFFSET+1:2];
                end
            end
            ST_WAIT: begin
                if (!req_cc2mem) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_BURST;
                    w_issue     = 1'b1;
                    w_beat_nxt  = r_beat + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_BURST: begin
                if (!req_cc2mem) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_beat == BEATS) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_issue    = 1'b1;
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            ST_DONE: begin
                if (!req_cc2mem) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, transaction context and registered beat/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_line  <= '0;
            r_start <= '0;
            r_ack   <= 1'b0;
            r_word  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
            r_line  <= w_line_nxt;
            r_start <= w_start_nxt;
            r_ack   <= w_issue;
            if (w_issue) begin
                r_word <= w_off;
            end
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    mem_resp_ram #(
        .DEPTH_LOG2 (MEM_DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .i_rd_en  (w_issue),
        .i_rd_adr (w_rd_adr),
        .o_rd_dat (dat_mem2cc),
        .i_wr_en  (ld_en),
        .i_wr_adr (ld_adr),
        .i_wr_dat (ld_dat)
    );

    assign ack_mem2cc    = r_ack;
    assign word_mem2mshr = r_word;
    assign busy          = r_busy;

endmodule

// File: tb/tb_mem_refill_responder.sv
// Bench for mem_refill_responder: a timeline reference model (beat k of a
// request lands LATENCY+k edges after acceptance) checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_refill_responder;
    import mem_resp_pkg::*;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned WO    = 2;
    localparam int unsigned MD    = 10;
    localparam int unsigned LAT   = 3;
    localparam int unsigned WPL   = WORDS_PER_LINE;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [ADR_W-1:0] adr;
    logic          ack;
    logic [DW-1:0] dat;
    logic [WO-1:0] word;
    logic          ld_en;
    logic [MD-1:0] ld_adr;
    logic [DW-1:0] ld_dat;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_refill_responder #(
        .ADR_WIDTH      (ADR_W),
        .DATA_WIDTH     (DW),
        .WORD_OFFSET    (WO),
        .MEM_DEPTH_LOG2 (MD),
        .LATENCY        (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_cc2mem    (req),
        .adr_cc2mem    (adr),
        .ack_mem2cc    (ack),
        .dat_mem2cc    (dat),
        .word_mem2mshr (word),
        .ld_en         (ld_en),
        .ld_adr        (ld_adr),
        .ld_dat        (ld_dat),
        .busy          (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [0:(1<<MD)-1];
    bit            m_live  = 0;
    bit            m_owned = 0;
    int            m_cyc   = 0;
    int            m_t0, m_line, m_start;
    logic          e_ack, e_busy;
    logic [DW-1:0] e_dat;
    logic [WO-1:0] e_word;

    always @(posedge clk) begin
        int idx, k, j, off;
        m_cyc++;
        if (rst) begin
            m_live = 1; m_owned = 0;
            e_ack = 0; e_busy = 0; e_dat = '0; e_word = '0;
        end else if (!m_owned) begin
            e_ack = 0;
            if (req) begin
                idx     = int'(adr[MD+1:2]);
                m_owned = 1;
                m_t0    = m_cyc;
                m_line  = idx / WPL;
                m_start = idx % WPL;
                e_busy  = 1;
            end else begin
                e_busy = 0;
            end
        end else begin
            k = m_cyc - m_t0;
            if (!req) begin
                m_owned = 0; e_ack = 0; e_busy = 0;
            end else if (k >= LAT && k < LAT + WPL) begin
                j = k - LAT;
`ifdef MEM_RESP_CWF_EN
                off = (m_start + j) % WPL;
`else
                off = j;
`endif
                e_ack  = 1;
                e_word = WO'(off);
                e_dat  = ref_mem[m_line * WPL + off];
                e_busy = 1;
            end else begin
                e_ack = 0; e_busy = 1;
            end
        end
        if (ld_en) ref_mem[ld_adr] = ld_dat;
    end

    // Per-cycle compare plus capture of every delivered beat.
    int          cap_w[$];
    logic [DW-1:0] cap_d[$];

    always @(negedge clk) begin
        if (m_live) begin
            chk("ack", 64'(ack), 64'(e_ack));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("word", 64'(word), 64'(e_word));
            chk("dat", 64'(dat), 64'(e_dat));
            if (ack === 1'b1) begin
                cap_w.push_back(int'(word));
                cap_d.push_back(dat);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_cap();
        cap_w.delete();
        cap_d.delete();
    endtask

    // Hold req until ack has been seen n times (bounded), counting beats.
    task automatic wait_acks(input int n, input string nm);
        int seen = 0;
        int budget = 40;
        while (seen < n && budget > 0) begin
            tick();
            budget--;
            if (ack === 1'b1) seen++;
        end
        if (seen < n) chk({nm, "_timeout"}, 64'(seen), 64'(n));
    endtask

    task automatic refill(input logic [ADR_W-1:0] a);
        clear_cap();
        req = 1; adr = a;
        wait_acks(WPL, "refill");
        tick();
        req = 0;
        tick(); tick();
    endtask

    task automatic check_beats(input string nm, input int w0, input int w1, input int w2, input int w3,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        int          ew[4];
        logic [DW-1:0] ed[4];
        ew = '{w0, w1, w2, w3};
        ed = '{d0, d1, d2, d3};
        chk({nm, "_nbeats"}, 64'(cap_w.size()), 64'(4));
        for (int i = 0; i < 4 && i < cap_w.size(); i++) begin
            chk($sformatf("%s_word%0d", nm, i), 64'(cap_w[i]), 64'(ew[i]));
            chk($sformatf("%s_dat%0d", nm, i), 64'(cap_d[i]), 64'(ed[i]));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int hold;
        rst = 1; req = 0; adr = '0; ld_en = 0; ld_adr = '0; ld_dat = '0;
        tick(); tick();
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_dat", 64'(dat), 64'(0));
        chk("rst_word", 64'(word), 64'(0));
        rst = 0;

        for (int i = 0; i < (1 << MD); i++) begin
            ld_en = 1; ld_adr = MD'(i); ld_dat = $urandom;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            ld_en = 1; ld_adr = MD'(32'h340 + i); ld_dat = 32'hA0 + i;
            tick();
        end
        ld_en = 0;
        tick();

        // Basic refill with latency measurement and a held request.
        clear_cap();
        req = 1; adr = 32'hFF07BD08;
        tick();
        lat = 0;
        while (ack !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("first_ack_latency", 64'(lat), 64'(3));
        tick(); tick(); tick();
        for (int i = 0; i < 10; i++) tick();
        chk("held_busy", 64'(busy), 64'(1));
        chk("held_ack", 64'(ack), 64'(0));
`ifdef MEM_RESP_CWF_EN
        check_beats("basic", 2, 3, 0, 1, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
`else
        check_beats("basic", 0, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
`endif
        req = 0;
        tick();
        chk("release_busy", 64'(busy), 64'(0));
        tick();

        // Wrap from offset 3.
        refill(32'hA5552D0C);
`ifdef MEM_RESP_CWF_EN
        check_beats("wrap", 3, 0, 1, 2, 32'hA3, 32'hA0, 32'hA1, 32'hA2);
`else
        check_beats("wrap", 0, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
`endif

        // Abort during WAIT.
        clear_cap();
        req = 1; adr = 32'h0000_0D00;
        tick(); tick();
        req = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("abort_wait_beats", 64'(cap_w.size()), 64'(0));

        // Abort after two beats.
        clear_cap();
        req = 1; adr = 32'h0000_0D00;
        wait_acks(2, "abort_burst");
        req = 0;
        tick();
        chk("abort_burst_ack", 64'(ack), 64'(0));
        for (int i = 0; i < 6; i++) tick();
        chk("abort_burst_beats", 64'(cap_w.size()), 64'(2));

        // Reset mid-burst, then a refill proves RAM contents survive.
        clear_cap();
        req = 1; adr = 32'h0000_0D00;
        wait_acks(2, "rst_burst");
        rst = 1; req = 0;
        tick();
        chk("rstb_ack", 64'(ack), 64'(0));
        chk("rstb_dat", 64'(dat), 64'(0));
        chk("rstb_word", 64'(word), 64'(0));
        chk("rstb_busy", 64'(busy), 64'(0));
        rst = 0;
        tick();
        refill(32'h0000_0D00);
        check_beats("after_rst", 0, 1, 2, 3, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

        // Load collides with the read of word 0x342.
        clear_cap();
        req = 1; adr = 32'h0000_0D00;
        wait_acks(2, "collide");
        ld_en = 1; ld_adr = 10'h342; ld_dat = 32'h5A5A0042;
        tick();
        ld_en = 0;
        chk("collide_old_dat", 64'(dat), 64'(32'hA2));
        tick(); tick();
        req = 0;
        tick(); tick();
        refill(32'h0000_0D00);
        check_beats("collide_new", 0, 1, 2, 3, 32'hA0, 32'hA1, 32'h5A5A0042, 32'hA3);

        // Randomized traffic against the model.
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                if (req) begin
                    req = 0; hold = int'($urandom_range(1, 3));
                end else begin
                    req = 1; hold = int'($urandom_range(1, 14));
                end
            end
            hold--;
            adr    = $urandom;
            ld_en  = ($urandom % 4) == 0;
            ld_adr = MD'($urandom);
            ld_dat = $urandom;
            rst    = ($urandom % 97) == 0;
            tick();
        end
        rst = 0; req = 0; ld_en = 0;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
